// File: rtl/image_packet_tx.sv
// Transmit framer for the image link: SYNC, frame ID, 16-bit length, paced payload
// and a 16-bit additive checksum, emitted one byte per strb at a fixed minimum pacing.
module image_packet_tx #(
  parameter int         PAYLOAD_LEN = 16,
  parameter int         BYTE_PERIOD = 2,
  parameter logic [7:0] SYNC_BYTE   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  frame_id,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  received_data,
  output logic        strb,
  output logic        dataRdy,
  output logic [15:0] header_image_data_checksum,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] LEN16       = 16'(PAYLOAD_LEN);
  localparam logic [7:0]  SLOT_RELOAD = 8'(BYTE_PERIOD - 1);

  // Each state names the byte most recently placed on received_data.
  typedef enum logic [2:0] {
    IDLE, SYNC, HDR_ID, HDR_LH, HDR_LL, PAYLOAD, CK_HI, CK_LO
  } state_t;

  state_t      state_reg;
  logic [7:0]  slot_reg;
  logic [7:0]  fid_reg;
  logic [15:0] count_reg;
  logic        slot_due;
  logic        pix_take;

  assign slot_due  = (slot_reg == 8'd0);
  // Payload phase starts once the low length byte has gone out.
  assign pix_ready = slot_due &&
                     ((state_reg == HDR_LL) ||
                      (state_reg == PAYLOAD && count_reg != LEN16));
  assign pix_take  = pix_ready && pix_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg                  <= IDLE;
      slot_reg                   <= 8'd0;
      fid_reg                    <= 8'd0;
      count_reg                  <= 16'd0;
      received_data              <= 8'd0;
      strb                       <= 1'b0;
      dataRdy                    <= 1'b0;
      header_image_data_checksum <= 16'd0;
      busy                       <= 1'b0;
      done                       <= 1'b0;
    end else begin
      strb <= 1'b0;
      done <= 1'b0;
      if (!slot_due) begin
        slot_reg <= slot_reg - 8'd1;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            fid_reg                    <= frame_id;
            header_image_data_checksum <= 16'd0;
            count_reg                  <= 16'd0;
            received_data              <= SYNC_BYTE;
            strb                       <= 1'b1;
            dataRdy                    <= 1'b1;
            busy                       <= 1'b1;
            slot_reg                   <= SLOT_RELOAD;
            state_reg                  <= SYNC;
          end
        end

        SYNC: begin
          if (slot_due) begin
            received_data              <= fid_reg;
            strb                       <= 1'b1;
            slot_reg                   <= SLOT_RELOAD;
            header_image_data_checksum <= header_image_data_checksum + {8'h00, fid_reg};
            state_reg                  <= HDR_ID;
          end
        end

        HDR_ID: begin
          if (slot_due) begin
            received_data              <= LEN16[15:8];
            strb                       <= 1'b1;
            slot_reg                   <= SLOT_RELOAD;
            header_image_data_checksum <= header_image_data_checksum + {8'h00, LEN16[15:8]};
            state_reg                  <= HDR_LH;
          end
        end

        HDR_LH: begin
          if (slot_due) begin
            received_data              <= LEN16[7:0];
            strb                       <= 1'b1;
            slot_reg                   <= SLOT_RELOAD;
            header_image_data_checksum <= header_image_data_checksum + {8'h00, LEN16[7:0]};
            state_reg                  <= HDR_LL;
          end
        end

        HDR_LL, PAYLOAD: begin
          // A due slot with no valid byte simply stalls with the slot counter at 0.
          if (pix_take) begin
            received_data              <= pix_data;
            strb                       <= 1'b1;
            slot_reg                   <= SLOT_RELOAD;
            header_image_data_checksum <= header_image_data_checksum + {8'h00, pix_data};
            count_reg                  <= count_reg + 16'd1;
            state_reg                  <= PAYLOAD;
          end else if (state_reg == PAYLOAD && slot_due && count_reg == LEN16) begin
            received_data <= header_image_data_checksum[15:8];
            strb          <= 1'b1;
            slot_reg      <= SLOT_RELOAD;
            state_reg     <= CK_HI;
          end
        end

        CK_HI: begin
          if (slot_due) begin
            received_data <= header_image_data_checksum[7:0];
            strb          <= 1'b1;
            slot_reg      <= SLOT_RELOAD;
            state_reg     <= CK_LO;
          end
        end

        CK_LO: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          dataRdy   <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
